// File: rtl/boolfuck_loader_if.sv
// boolfuck_loader_if: source byte stream plus interpreter key-press bundle
interface boolfuck_loader_if #(parameter int C = 8);
  logic in_valid, in_ready, in_last, start, lft, rgt, ctl, busy, done, err;
  logic [7:0] in_data, key;
  logic [1:0] blk_i;
  logic [C-1:0] cur_i;
  modport master(
    input in_valid, in_data, in_last, start, blk_i, cur_i,
    output in_ready, lft, rgt, ctl, key, busy, done, err
  );
  modport slave(
    output in_valid, in_data, in_last, start, blk_i, cur_i,
    input in_ready, lft, rgt, ctl, key, busy, done, err
  );
endinterface

// File: rtl/boolfuck_loader.sv
// boolfuck_loader: types a boolfuck byte stream into the interpreter's edit mode as key presses
module boolfuck_loader #(
  parameter int C = 8,
  parameter int GAP = 1,
  parameter bit AUTORUN = 1
) (
  input logic clk,
  input logic rst,
  boolfuck_loader_if.master bus
);
  localparam int GW = $clog2(GAP + 2);
  localparam logic [GW-1:0] HOLD = GW'(GAP + 1);
  typedef enum logic [2:0] {ALIGN, ACCEPT, TERM, RUN, DONE} state_t;
  state_t state, state_n;
  logic [GW-1:0] gap, gap_n;
  logic [C-1:0] count, count_n;
  logic err_n, lft_n, rgt_n, ctl_n, idle, hs, full;
  logic [7:0] key_n, code;
  assign code = bus.in_data == "+" ? 8'h02 :
                bus.in_data == "<" ? 8'h04 :
                bus.in_data == ">" ? 8'h08 :
                bus.in_data == ";" ? 8'h10 :
                bus.in_data == "," ? 8'h20 :
                bus.in_data == "[" ? 8'h40 :
                bus.in_data == "]" ? 8'h80 : 8'h00;
  // gap counts the press cycle plus the low cycles that follow it
  assign idle = gap == '0;
  assign full = &count;
  assign bus.in_ready = state == ACCEPT && idle;
  assign hs = bus.in_valid && bus.in_ready;
  assign bus.done = state == DONE;
  assign bus.busy = state != DONE;
  always_comb begin
    state_n = state;
    gap_n = idle ? gap : gap - 1'b1;
    count_n = count;
    err_n = bus.err;
    lft_n = 1'b0;
    rgt_n = 1'b0;
    ctl_n = 1'b0;
    key_n = 8'h00;
    if (state == DONE) begin
      if (bus.start) begin
        state_n = ALIGN;
        err_n = 1'b0;
      end
    end else if (idle) begin
      if (state == ALIGN) begin
        if (bus.blk_i != 2'b11) ctl_n = 1'b1;
        else if (bus.cur_i != '0) begin
          lft_n = !bus.cur_i[C-1];
          rgt_n = bus.cur_i[C-1];
        end else begin
          state_n = ACCEPT;
          count_n = '0;
        end
      end else if (state == ACCEPT) begin
        // the last slot is kept free for the halt opcode
        if (hs && code != 8'h00) begin
          if (full) err_n = 1'b1;
          else begin
            key_n = code;
            count_n = count + 1'b1;
          end
        end
        if (hs && bus.in_last) state_n = TERM;
      end else if (state == TERM) begin
        key_n = 8'h01;
        state_n = AUTORUN ? RUN : DONE;
      end else begin
        ctl_n = 1'b1;
        state_n = DONE;
      end
    end
    if (lft_n || rgt_n || ctl_n || key_n != 8'h00) gap_n = HOLD;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ALIGN;
      gap <= '0;
      count <= '0;
      bus.err <= 1'b0;
      bus.lft <= 1'b0;
      bus.rgt <= 1'b0;
      bus.ctl <= 1'b0;
      bus.key <= 8'h00;
    end else begin
      state <= state_n;
      gap <= gap_n;
      count <= count_n;
      bus.err <= err_n;
      bus.lft <= lft_n;
      bus.rgt <= rgt_n;
      bus.ctl <= ctl_n;
      bus.key <= key_n;
    end
  end
endmodule

// File: tb/tb_boolfuck_loader.sv
// tb_boolfuck_loader: random loads checked against a press-sequence model and a behavioural interpreter
module tb_boolfuck_loader;
  logic clk = 0, rst = 1, mrst = 1, sel = 0;
  logic in_valid = 0, in_last = 0, start = 0;
  logic [7:0] in_data = 0;
  logic [1:0] blk, init_blk = 0;
  logic [2:0] cur, init_cur = 0;
  int prg [8];
  logic [10:0] p_press;
  logic m_ready, m_busy, m_done, m_err;
  logic [10:0] m_press;
  int pass_n = 0, fail_n = 0, cyc = 0, since = 100;
  logic [10:0] exp_q [$];
  logic [10:0] plog [$];
  int ptime [$];
  int hs [$];
  logic [7:0] alpha [12] = '{"+", "<", ">", ";", ",", "[", "]", "a", " ", 8'h0a, "#", "+"};

  boolfuck_loader_if #(.C(3)) ia();
  boolfuck_loader_if #(.C(3)) ib();
  boolfuck_loader #(.C(3), .GAP(2), .AUTORUN(1)) dut_a (.clk(clk), .rst(rst), .bus(ia));
  boolfuck_loader #(.C(3), .GAP(1), .AUTORUN(0)) dut_b (.clk(clk), .rst(rst), .bus(ib));

  always #5 clk = ~clk;

  assign ia.in_valid = in_valid && !sel;
  assign ib.in_valid = in_valid && sel;
  assign ia.in_data = in_data;
  assign ib.in_data = in_data;
  assign ia.in_last = in_last;
  assign ib.in_last = in_last;
  assign ia.start = start && !sel;
  assign ib.start = start && sel;
  assign ia.blk_i = blk;
  assign ib.blk_i = blk;
  assign ia.cur_i = cur;
  assign ib.cur_i = cur;
  assign m_ready = sel ? ib.in_ready : ia.in_ready;
  assign m_busy = sel ? ib.busy : ia.busy;
  assign m_done = sel ? ib.done : ia.done;
  assign m_err = sel ? ib.err : ia.err;
  assign m_press = sel ? {ib.lft, ib.rgt, ib.ctl, ib.key} : {ia.lft, ia.rgt, ia.ctl, ia.key};

  function automatic int idx(logic [7:0] k);
    for (int i = 0; i < 8; i++) if (k[i]) return i;
    return -2;
  endfunction

  function automatic logic [7:0] code(logic [7:0] ch);
    case (ch)
      "+": return 8'h02;
      "<": return 8'h04;
      ">": return 8'h08;
      ";": return 8'h10;
      ",": return 8'h20;
      "[": return 8'h40;
      "]": return 8'h80;
      default: return 8'h00;
    endcase
  endfunction

  // interpreter: reacts to rising presses; ctl toggles edit/run, keys write at cur and advance
  always @(posedge clk) begin
    if (mrst) begin
      blk <= init_blk;
      cur <= init_cur;
      for (int i = 0; i < 8; i++) prg[i] <= -1;
    end else begin
      if (m_press[8] && !p_press[8]) blk <= blk == 2'b11 ? 2'b00 : 2'b11;
      if (blk == 2'b11 && m_press[10] && !p_press[10]) cur <= cur - 3'd1;
      if (blk == 2'b11 && m_press[9] && !p_press[9]) cur <= cur + 3'd1;
      if (blk == 2'b11 && m_press[7:0] != 0 && p_press[7:0] == 0) begin
        prg[cur] <= idx(m_press[7:0]);
        cur <= cur + 3'd1;
      end
    end
    p_press <= m_press;
  end

  task automatic chk(string name, int act, int exp);
    if (act == exp) pass_n++;
    else begin
      fail_n++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (rst) since = 100;
    else begin
      chk("onehot", int'($onehot0(m_press)), 1);
      chk("busy_done", int'(m_busy), int'(!m_done));
      if (m_ready) chk("ready_gap", int'(m_press == 0 && since >= (sel ? 1 : 2)), 1);
      if (m_press != 0) begin
        chk("press_gap", int'(since >= (sel ? 1 : 2)), 1);
        plog.push_back(m_press);
        ptime.push_back(cyc);
        if (exp_q.size() == 0) chk("extra_press", int'(m_press), 0);
        else chk("press", int'(m_press), int'(exp_q.pop_front()));
        since = 0;
      end else since++;
    end
  endtask

  task automatic reset_to(logic s, logic [1:0] b, logic [2:0] c);
    sel = s;
    init_blk = b;
    init_cur = c;
    rst = 1;
    mrst = 1;
    in_valid = 0;
    start = 0;
    tick();
    tick();
    chk("rst_press", int'(m_press), 0);
    chk("rst_ready", int'(m_ready), 0);
    chk("rst_done", int'(m_done), 0);
    chk("rst_err", int'(m_err), 0);
    chk("rst_busy", int'(m_busy), 1);
    rst = 0;
    mrst = 0;
  endtask

  task automatic load(logic [7:0] prog [$], logic do_start, logic bub);
    logic [1:0] b;
    logic [2:0] c;
    int n, m, t;
    logic e;
    int exp_prg [8];
    b = blk;
    c = cur;
    n = 0;
    e = 0;
    m = c < 3'd4 ? int'(c) : 8 - int'(c);
    exp_q.delete();
    plog.delete();
    ptime.delete();
    hs.delete();
    if (b != 2'b11) exp_q.push_back(11'h100);
    repeat (m) exp_q.push_back(c < 3'd4 ? 11'h400 : 11'h200);
    foreach (prog[i]) if (code(prog[i]) != 0) begin
      if (n < 7) begin
        exp_prg[n] = idx(code(prog[i]));
        exp_q.push_back({3'b000, code(prog[i])});
        n++;
      end else e = 1;
    end
    exp_prg[n] = 0;
    exp_q.push_back(11'h001);
    if (!sel) exp_q.push_back(11'h100);
    if (do_start) begin
      start = 1;
      tick();
      start = 0;
      chk("start_busy", int'(m_busy), 1);
    end
    foreach (prog[i]) begin
      if (bub && $urandom_range(0, 3) == 0) begin
        in_valid = 0;
        tick();
      end
      in_valid = 1;
      in_data = prog[i];
      in_last = i == prog.size() - 1;
      t = 0;
      while (!m_ready && t < 300) begin
        tick();
        t++;
      end
      if (!m_ready) begin
        chk("ready_timeout", 0, 1);
        break;
      end
      if (i == 0) begin
        chk("align_cur", int'(cur), 0);
        chk("align_blk", int'(blk), 3);
      end
      hs.push_back(cyc);
      tick();
    end
    in_valid = 0;
    in_last = 0;
    chk("ready_after_last", int'(m_ready), 0);
    t = 0;
    while (!m_done && t < 400) begin
      tick();
      t++;
    end
    chk("done", int'(m_done), 1);
    repeat (4) tick();
    chk("presses_left", exp_q.size(), 0);
    chk("err", int'(m_err), int'(e));
    for (int i = 0; i <= n; i++) chk("prg", prg[i], exp_prg[i]);
    chk("blk_end", int'(blk), sel ? 3 : 0);
    chk("ready_done", int'(m_ready), 0);
  endtask

  initial begin
    logic [7:0] p [$];
    int t;
    // out of edit mode, cur=3: ctl then three lft presses before the first byte
    reset_to(0, 2'b00, 3'd3);
    p = '{"+", ">", "[", "]"};
    load(p, 0, 0);
    chk("t1_ctl", int'(plog[0]), 'h100);
    for (int i = 1; i < 4; i++) chk("t1_lft", int'(plog[i]), 'h400);
    chk("t1_count", plog.size(), 10);
    // GAP=1, no autorun: keys spaced three cycles, halt, no trailing ctl
    reset_to(1, 2'b11, 3'd0);
    load(p, 0, 0);
    chk("t2_count", plog.size(), 5);
    chk("t2_halt", int'(plog[4]), 'h001);
    for (int i = 1; i < 5; i++) chk("t2_space", ptime[i] - ptime[i-1], 3);
    chk("t2_prg0", prg[0], 1);
    chk("t2_prg1", prg[1], 3);
    chk("t2_prg2", prg[2], 6);
    chk("t2_prg3", prg[3], 7);
    chk("t2_prg4", prg[4], 0);
    chk("t6_blk", int'(blk), 3);
    p = '{"<", "x", ";"};
    load(p, 1, 1);
    // comments are swallowed one per cycle
    reset_to(0, 2'b11, 3'd0);
    p = '{"a", "+", " ", "b", 8'h0a};
    load(p, 0, 0);
    chk("t3_hs_ab", hs[1] - hs[0], 1);
    chk("t3_hs_key", hs[2] - hs[1], 4);
    chk("t3_hs_cm", hs[3] - hs[2], 1);
    chk("t3_count", plog.size(), 3);
    chk("t3_key", int'(plog[0]), 'h002);
    // memory full: seven keys, eighth dropped, halt at the last address
    reset_to(0, 2'b11, 3'd5);
    p = '{"+", "+", "+", "+", "+", "+", "+", "+", 8'h0a};
    load(p, 0, 1);
    chk("t4_count", plog.size(), 12);
    chk("t4_err", int'(m_err), 1);
    chk("t4_prg7", prg[7], 0);
    // reset while a key press is on the wire
    reset_to(0, 2'b11, 3'd0);
    exp_q.delete();
    exp_q.push_back(11'h040);
    in_valid = 1;
    in_data = "[";
    in_last = 0;
    t = 0;
    while (!m_ready && t < 50) begin
      tick();
      t++;
    end
    tick();
    in_valid = 0;
    chk("t5_key", int'(m_press), 'h040);
    rst = 1;
    tick();
    chk("t5_key0", int'(m_press), 0);
    chk("t5_ready", int'(m_ready), 0);
    chk("t5_busy", int'(m_busy), 1);
    chk("t5_cur", int'(cur), 1);
    chk("t5_prg0", prg[0], 6);
    rst = 0;
    p = '{">", "]"};
    load(p, 0, 1);
    for (int k = 0; k < 30; k++) begin
      reset_to(1'($urandom_range(0, 1)), 2'($urandom), 3'($urandom));
      p.delete();
      repeat ($urandom_range(1, 12)) p.push_back(alpha[$urandom_range(0, 11)]);
      load(p, 0, 1);
      if (sel && $urandom_range(0, 1) == 1) begin
        p.delete();
        repeat ($urandom_range(1, 12)) p.push_back(alpha[$urandom_range(0, 11)]);
        load(p, 1, 1);
      end
    end
    $display("%0d/%0d checks passed", pass_n, pass_n + fail_n);
    $finish;
  end
endmodule
